// File: rtl/riscv_defines.sv
// Shared definitions for the mixed-precision operand path: format encoding,
// CSR addresses, widths and the format-to-geometry mapping.
package riscv_defines;

  localparam int NBITS_MIXED_CYCLES = 3;
  localparam int NBITS_MAX_KER      = 16;

  localparam logic [11:0] MPC_CSR_FMT   = 12'h00C;
  localparam logic [11:0] MPC_CSR_CYCLE = 12'h00D;
  localparam logic [11:0] MPC_CSR_SKIP  = 12'h00E;

  // Encoding 0 and 7 are non-mixed: the operand passes through unchanged.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_2X4  = 3'd1,
    FMT_4X8  = 3'd2,
    FMT_8X16 = 3'd3,
    FMT_2X8  = 3'd4,
    FMT_4X16 = 3'd5,
    FMT_2X16 = 3'd6,
    FMT_RSVD = 3'd7
  } ivec_mode_fmt;

  typedef struct packed {
    logic [4:0] w;
    logic [4:0] a;
    logic [3:0] cycles;
  } fmt_params_t;

  function automatic fmt_params_t fmt_params(input ivec_mode_fmt fmt);
    fmt_params_t p;
    case (fmt)
      FMT_2X4:  p = '{w: 5'd2, a: 5'd4,  cycles: 4'd2};
      FMT_4X8:  p = '{w: 5'd4, a: 5'd8,  cycles: 4'd2};
      FMT_8X16: p = '{w: 5'd8, a: 5'd16, cycles: 4'd2};
      FMT_2X8:  p = '{w: 5'd2, a: 5'd8,  cycles: 4'd4};
      FMT_4X16: p = '{w: 5'd4, a: 5'd16, cycles: 4'd4};
      FMT_2X16: p = '{w: 5'd2, a: 5'd16, cycles: 4'd8};
      default:  p = '{w: 5'd0, a: 5'd0,  cycles: 4'd1};
    endcase
    return p;
  endfunction

  // Cycle counts are powers of two, so masking equals wrapping modulo cycles.
  function automatic logic [NBITS_MIXED_CYCLES-1:0] fmt_cycle_mask(input ivec_mode_fmt fmt);
    fmt_params_t p;
    p = fmt_params(fmt);
    return NBITS_MIXED_CYCLES'(p.cycles - 4'd1);
  endfunction

endpackage

// File: rtl/mpc_slice_extend.sv
// Combinational slice selection and per-lane widening of a packed
// narrow-weight operand into A-bit lanes.
module mpc_slice_extend
  import riscv_defines::*;
(
  input  logic [31:0]                   rs2,
  input  ivec_mode_fmt                  fmt,
  input  logic [NBITS_MIXED_CYCLES-1:0] cycle,
  input  logic                          sgn,
  output logic [31:0]                   data
);

  // Select the cycle's S-bit window, then place each W-bit field at lane k
  // of width A, filling the upper bits with the field's sign or zero.
  function automatic logic [31:0] expand(input logic [31:0] src,
                                         input logic [NBITS_MIXED_CYCLES-1:0] c,
                                         input int w, input int a, input logic s);
    logic [31:0] win;
    logic [31:0] r;
    int lanes;
    int lane;
    int pos;
    lanes = 32 / a;
    win   = src >> (32'(c) * 32'(lanes * w));
    r     = '0;
    for (int i = 0; i < 32; i++) begin
      lane = i / a;
      pos  = i % a;
      if (pos < w) r[i] = win[5'(lane * w + pos)];
      else         r[i] = s & win[5'(lane * w + w - 1)];
    end
    return r;
  endfunction

  always_comb begin
    data = rs2;
    case (fmt)
      FMT_2X4:  data = expand(rs2, cycle, 2, 4,  sgn);
      FMT_4X8:  data = expand(rs2, cycle, 4, 8,  sgn);
      FMT_8X16: data = expand(rs2, cycle, 8, 16, sgn);
      FMT_2X8:  data = expand(rs2, cycle, 2, 8,  sgn);
      FMT_4X16: data = expand(rs2, cycle, 4, 16, sgn);
      FMT_2X16: data = expand(rs2, cycle, 2, 16, sgn);
      default:  data = rs2;
    endcase
  end

endmodule

// File: rtl/mixed_precision_operand_unit.sv
// Mixed-precision CSR state (format, cycle, skip size) plus a one-entry
// registered stage that emits the expanded narrow-weight operand slice.
module mixed_precision_operand_unit
  import riscv_defines::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          csr_we_i,
  input  logic [11:0]                   csr_addr_i,
  input  logic [31:0]                   csr_wdata_i,
  output logic [31:0]                   csr_rdata_o,
  input  logic                          mux_sel_wcsr_i,
  input  logic [NBITS_MIXED_CYCLES-1:0] next_cycle_i,
  output logic [NBITS_MIXED_CYCLES-1:0] current_cycle_o,
  output ivec_mode_fmt                  ivec_fmt_o,
  output logic [NBITS_MAX_KER-1:0]      skip_size_o,
  input  logic                          op_valid_i,
  output logic                          op_ready_o,
  input  logic [31:0]                   op_rs2_i,
  input  logic                          op_signed_i,
  output logic                          slice_valid_o,
  input  logic                          slice_ready_i,
  output logic [31:0]                   slice_data_o,
  output logic [NBITS_MIXED_CYCLES-1:0] slice_cycle_o
);

  logic                          wr_fmt;
  logic                          wr_cycle;
  logic                          wr_skip;
  logic [NBITS_MIXED_CYCLES-1:0] cycle_mask;
  logic [31:0]                   ext_data;
  logic                          accept;
  logic                          unused_wdata;

  assign wr_fmt       = csr_we_i && (csr_addr_i == MPC_CSR_FMT);
  assign wr_cycle     = csr_we_i && (csr_addr_i == MPC_CSR_CYCLE);
  assign wr_skip      = csr_we_i && (csr_addr_i == MPC_CSR_SKIP);
  assign cycle_mask   = fmt_cycle_mask(ivec_fmt_o);
  assign unused_wdata = ^csr_wdata_i[31:NBITS_MAX_KER];

  // Software writes beat the controller's write-back; a format change
  // restarts the cycle sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ivec_fmt_o      <= FMT_NONE;
      current_cycle_o <= '0;
      skip_size_o     <= '0;
    end else begin
      if (wr_fmt) ivec_fmt_o <= ivec_mode_fmt'(csr_wdata_i[2:0]);
      if (wr_skip) skip_size_o <= csr_wdata_i[NBITS_MAX_KER-1:0];
      if (wr_cycle)
        current_cycle_o <= csr_wdata_i[NBITS_MIXED_CYCLES-1:0] & cycle_mask;
      else if (wr_fmt)
        current_cycle_o <= '0;
      else if (mux_sel_wcsr_i)
        current_cycle_o <= next_cycle_i & cycle_mask;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      MPC_CSR_FMT:   csr_rdata_o = 32'(ivec_fmt_o);
      MPC_CSR_CYCLE: csr_rdata_o = 32'(current_cycle_o);
      MPC_CSR_SKIP:  csr_rdata_o = 32'(skip_size_o);
      default:       csr_rdata_o = '0;
    endcase
  end

  mpc_slice_extend u_extend (
    .rs2   (op_rs2_i),
    .fmt   (ivec_fmt_o),
    .cycle (current_cycle_o),
    .sgn   (op_signed_i),
    .data  (ext_data)
  );

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a held slice stays stable.
  assign op_ready_o = !slice_valid_o || slice_ready_i;
  assign accept     = op_valid_i && op_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_valid_o <= 1'b0;
      slice_data_o  <= '0;
      slice_cycle_o <= '0;
    end else if (accept) begin
      slice_valid_o <= 1'b1;
      slice_data_o  <= ext_data;
      slice_cycle_o <= current_cycle_o;
    end else if (slice_ready_i) begin
      slice_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mixed_precision_operand_unit.sv
// Bench for mixed_precision_operand_unit: directed scenarios then random
// traffic, checked against an arithmetic model of the slicing rules.
module tb_mixed_precision_operand_unit;
  import riscv_defines::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         csr_we_i = 1'b0;
  logic [11:0]  csr_addr_i = '0;
  logic [31:0]  csr_wdata_i = '0;
  logic [31:0]  csr_rdata_o;
  logic         mux_sel_wcsr_i = 1'b0;
  logic [2:0]   next_cycle_i = '0;
  logic [2:0]   current_cycle_o;
  ivec_mode_fmt ivec_fmt_o;
  logic [15:0]  skip_size_o;
  logic         op_valid_i = 1'b0;
  logic         op_ready_o;
  logic [31:0]  op_rs2_i = '0;
  logic         op_signed_i = 1'b0;
  logic         slice_valid_o;
  logic         slice_ready_i = 1'b0;
  logic [31:0]  slice_data_o;
  logic [2:0]   slice_cycle_o;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural model state and the slice scoreboard ({cycle, data}).
  int          m_fmt, m_cycle, m_skip;
  logic [34:0] exp_q[$];

  mixed_precision_operand_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_we_i        (csr_we_i),
    .csr_addr_i      (csr_addr_i),
    .csr_wdata_i     (csr_wdata_i),
    .csr_rdata_o     (csr_rdata_o),
    .mux_sel_wcsr_i  (mux_sel_wcsr_i),
    .next_cycle_i    (next_cycle_i),
    .current_cycle_o (current_cycle_o),
    .ivec_fmt_o      (ivec_fmt_o),
    .skip_size_o     (skip_size_o),
    .op_valid_i      (op_valid_i),
    .op_ready_o      (op_ready_o),
    .op_rs2_i        (op_rs2_i),
    .op_signed_i     (op_signed_i),
    .slice_valid_o   (slice_valid_o),
    .slice_ready_i   (slice_ready_i),
    .slice_data_o    (slice_data_o),
    .slice_cycle_o   (slice_cycle_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void fmt_table(input int fmt, output int w, output int a, output int n);
    case (fmt)
      1: begin w = 2; a = 4;  n = 2; end
      2: begin w = 4; a = 8;  n = 2; end
      3: begin w = 8; a = 16; n = 2; end
      4: begin w = 2; a = 8;  n = 4; end
      5: begin w = 4; a = 16; n = 4; end
      6: begin w = 2; a = 16; n = 8; end
      default: begin w = 32; a = 32; n = 1; end
    endcase
  endfunction

  function automatic int fmt_cycles(input int fmt);
    int w, a, n;
    fmt_table(fmt, w, a, n);
    return n;
  endfunction

  function automatic logic [31:0] model_slice(input logic [31:0] rs2, input int fmt,
                                              input int c, input logic sg);
    int w, a, n, lanes, f;
    longint r;
    fmt_table(fmt, w, a, n);
    if (n == 1) return rs2;
    lanes = 32 / a;
    r = 0;
    for (int k = 0; k < lanes; k++) begin
      f = int'((rs2 >> ((c * lanes + k) * w)) & ((32'd1 << w) - 32'd1));
      if (sg && f >= (1 << (w - 1))) f -= (1 << w);
      r += longint'(f & ((1 << a) - 1)) << (k * a);
    end
    return r[31:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0;
    mux_sel_wcsr_i = 1'b0; next_cycle_i = '0;
    op_valid_i = 1'b0; op_rs2_i = '0; op_signed_i = 1'b0; slice_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_fmt = 0; m_cycle = 0; m_skip = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus, called at a falling edge: check the state left by
  // the previous edge, drive inputs, advance the model, wait for next fall.
  task automatic step(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                      input logic hw, input logic [2:0] nc, input logic v,
                      input logic [31:0] rs2, input logic sg, input logic rdy);
    logic [31:0] rd_exp;
    bit had;
    check("cycle", 35'(current_cycle_o), 35'(m_cycle));
    check("fmt", 35'(ivec_fmt_o), 35'(m_fmt));
    check("skip", 35'(skip_size_o), 35'(m_skip));
    check("slice_valid", 35'(slice_valid_o), 35'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("slice", {slice_cycle_o, slice_data_o}, exp_q[0]);
    csr_we_i = we; csr_addr_i = addr; csr_wdata_i = wd;
    mux_sel_wcsr_i = hw; next_cycle_i = nc;
    op_valid_i = v; op_rs2_i = rs2; op_signed_i = sg; slice_ready_i = rdy;
    #1;
    check("op_ready", 35'(op_ready_o), 35'(exp_q.size() == 0 || rdy));
    case (addr)
      MPC_CSR_FMT:   rd_exp = 32'(m_fmt);
      MPC_CSR_CYCLE: rd_exp = 32'(m_cycle);
      MPC_CSR_SKIP:  rd_exp = 32'(m_skip);
      default:       rd_exp = '0;
    endcase
    check("rdata", 35'(csr_rdata_o), 35'(rd_exp));
    had = exp_q.size() != 0;
    if (had && rdy) void'(exp_q.pop_front());
    if (v && (!had || rdy)) exp_q.push_back({3'(m_cycle), model_slice(rs2, m_fmt, m_cycle, sg)});
    if (we && addr == MPC_CSR_CYCLE)    m_cycle = int'(wd % 32'(fmt_cycles(m_fmt)));
    else if (we && addr == MPC_CSR_FMT) begin m_fmt = int'(wd[2:0]); m_cycle = 0; end
    else if (hw)                        m_cycle = int'(nc) % fmt_cycles(m_fmt);
    if (we && addr == MPC_CSR_SKIP) m_skip = int'(wd[15:0]);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 12'h000, '0, 1'b0, 3'd0, 1'b0, '0, 1'b0, rdy);
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] wd);
    step(1'b1, addr, wd, 1'b0, 3'd0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic send(input logic [31:0] rs2, input logic sg, input logic rdy);
    step(1'b0, 12'h000, '0, 1'b0, 3'd0, 1'b1, rs2, sg, rdy);
  endtask

  initial begin
    logic [31:0] held;
    logic [11:0] addrs[4];
    addrs[0] = MPC_CSR_FMT; addrs[1] = MPC_CSR_CYCLE; addrs[2] = MPC_CSR_SKIP; addrs[3] = 12'h123;
    do_reset();

    // Reset values
    check("rst_valid", 35'(slice_valid_o), 35'd0);
    check("rst_data", 35'(slice_data_o), 35'd0);
    check("rst_ready", 35'(op_ready_o), 35'd1);
    foreach (addrs[i]) step(1'b0, addrs[i], '0, 1'b0, 3'd0, 1'b0, '0, 1'b0, 1'b0);

    // 4x8, cycle 0, signed then unsigned
    csr_wr(MPC_CSR_FMT, 32'd2);
    send(32'h0000_00F7, 1'b1, 1'b1);
    check("s4x8_signed", 35'(slice_data_o), 35'h0000_FF07);
    send(32'h0000_00F7, 1'b0, 1'b1);
    check("s4x8_unsigned", 35'(slice_data_o), 35'h0000_0F07);
    idle(1'b1);

    // 2x16: controller steps cycle 1..7 then 0 while slices flow
    csr_wr(MPC_CSR_FMT, 32'd6);
    for (int n = 1; n <= 8; n++) begin
      step(1'b0, 12'h000, '0, 1'b1, 3'(n % 8), 1'b1, 32'h8765_4321, 1'b1, 1'b1);
      check("hw_cycle", 35'(current_cycle_o), 35'(n % 8));
    end
    idle(1'b1);

    // 2x8: software cycle write beats hardware update; value wraps mod 4
    csr_wr(MPC_CSR_FMT, 32'd4);
    step(1'b1, MPC_CSR_CYCLE, 32'd3, 1'b1, 3'd1, 1'b0, '0, 1'b0, 1'b1);
    check("sw_over_hw", 35'(current_cycle_o), 35'd3);
    csr_wr(MPC_CSR_CYCLE, 32'd5);
    check("cycle_wrap", 35'(current_cycle_o), 35'd1);
    csr_wr(MPC_CSR_SKIP, 32'hABCD_1234);
    check("skip", 35'(skip_size_o), 35'h1234);

    // Backpressure: three stalled cycles with valid held high
    send(32'h1234_5678, 1'b1, 1'b1);
    held = slice_data_o;
    for (int i = 0; i < 3; i++) begin
      send(32'hCAFE_F00D, 1'b1, 1'b0);
      check("bp_hold", 35'(slice_data_o), 35'(held));
      check("bp_ready", 35'(op_ready_o), 35'd0);
    end
    send(32'hCAFE_F00D, 1'b1, 1'b1);
    check("bp_next", 35'(slice_data_o), 35'(model_slice(32'hCAFE_F00D, 4, 1, 1'b1)));
    idle(1'b1);

    // Non-mixed pass-through, then async reset during a stall
    csr_wr(MPC_CSR_FMT, 32'd0);
    send(32'hDEAD_BEEF, 1'b0, 1'b1);
    check("nonmixed", {slice_cycle_o, slice_data_o}, {3'd0, 32'hDEAD_BEEF});
    idle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 35'(slice_valid_o), 35'd0);
    check("async_ready", 35'(op_ready_o), 35'd1);
    do_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [11:0] addr;
      case ($urandom_range(0, 3))
        0: addr = MPC_CSR_FMT;
        1: addr = MPC_CSR_CYCLE;
        2: addr = MPC_CSR_SKIP;
        default: addr = 12'($urandom_range(0, 4095));
      endcase
      step($urandom_range(0, 5) == 0, addr, $urandom, $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
